// File: rtl/level_meter_pkg.sv
// Shared types and helpers for the level-meter display path.
//   state_e   : frame scheduler state (COLLECT while waiting for a full set of
//               fresh arrays, EMIT while streaming a frame out)
//   chan_bits : width of a channel index for n channels, never below 1
package level_meter_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  function automatic int chan_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_frame_buffer.sv
// Per-channel latest-wins input buffers plus the frame snapshot.
//   clk, reset  : clock, asynchronous active-high reset
//   wr_en       : per-channel write strobe (valid && ready)
//   wr_data     : packed input arrays, channel c at [c*indicator_width +: indicator_width]
//   snap        : take a snapshot this cycle
//   all_fresh   : every channel has written since the last snapshot
//   buf_data    : current buffer contents (pre-write this cycle)
//   frame_data  : snapshot frame, same packing as wr_data
//   overrun     : sticky per-channel "overwritten before snapshot" flags
module level_frame_buffer #(
  parameter int channel_count   = 2,
  parameter int indicator_width = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [channel_count-1:0]                 wr_en,
  input  logic [channel_count*indicator_width-1:0] wr_data,
  input  logic                                     snap,
  output logic                                     all_fresh,
  output logic [channel_count*indicator_width-1:0] buf_data,
  output logic [channel_count*indicator_width-1:0] frame_data,
  output logic [channel_count-1:0]                 overrun
);

  localparam int W = channel_count * indicator_width;

  logic [W-1:0]             buf_q, buf_d;
  logic [W-1:0]             frame_q, frame_d;
  logic [channel_count-1:0] fresh_q, fresh_d;
  logic [channel_count-1:0] overrun_q, overrun_d;

  always_comb begin
    buf_d   = buf_q;
    frame_d = frame_q;
    for (int c = 0; c < channel_count; c++) begin
      if (wr_en[c]) buf_d[c*indicator_width +: indicator_width] =
                      wr_data[c*indicator_width +: indicator_width];
    end
    // Snapshot copies pre-write contents; a same-cycle write counts toward
    // the next frame instead of being an overrun of this one.
    if (snap) frame_d = buf_q;
    fresh_d   = snap ? wr_en : (fresh_q | wr_en);
    overrun_d = overrun_q | (wr_en & fresh_q & {channel_count{~snap}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q     <= '0;
      frame_q   <= '0;
      fresh_q   <= '0;
      overrun_q <= '0;
    end else begin
      buf_q     <= buf_d;
      frame_q   <= frame_d;
      fresh_q   <= fresh_d;
      overrun_q <= overrun_d;
    end
  end

  assign all_fresh  = &fresh_q;
  assign buf_data   = buf_q;
  assign frame_data = frame_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/level_frame_scheduler.sv
// Collects indicator arrays from all audio channels and streams them to the
// display driver as ordered frames (channel 0..channel_count-1, last marker).
//   clk, reset : clock, asynchronous active-high reset
//   i_valid    : per-channel array valid (never back-pressured)
//   i_ready    : per-channel ready, all ones from the first edge after reset
//   i_array    : packed arrays, channel c at [c*indicator_width +: indicator_width]
//   o_valid/o_ready : frame beat handshake
//   o_channel  : channel of the current beat
//   o_last     : final beat of the frame
//   o_array    : array of the current beat
//   o_overrun  : sticky per-channel overrun flags
// All outputs come straight from flops.
module level_frame_scheduler
  import level_meter_pkg::*;
#(
  parameter  int channel_count   = 2,
  parameter  int indicator_width = 32,
  localparam int channel_bits    = chan_bits(channel_count)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [channel_count-1:0]                 i_valid,
  output logic [channel_count-1:0]                 i_ready,
  input  logic [channel_count*indicator_width-1:0] i_array,
  output logic                                     o_valid,
  input  logic                                     o_ready,
  output logic [channel_bits-1:0]                  o_channel,
  output logic                                     o_last,
  output logic [indicator_width-1:0]               o_array,
  output logic [channel_count-1:0]                 o_overrun
);

  localparam logic [channel_bits-1:0] LAST_IDX = channel_bits'(channel_count - 1);

  state_e                         state_q, state_d;
  logic [channel_bits-1:0]        idx_q, idx_d;
  logic [channel_count-1:0]       i_ready_q;
  logic                           o_valid_q, o_valid_d;
  logic                           o_last_q, o_last_d;
  logic [indicator_width-1:0]     o_array_q, o_array_d;

  logic                           all_fresh;
  logic [channel_count*indicator_width-1:0] buf_data, frame_data;
  logic                           hs, snap_ok;
  logic [channel_bits-1:0]        next_idx;

  assign hs      = o_valid_q && o_ready;
  assign snap_ok = all_fresh && (state_q == COLLECT || (hs && o_last_q));

  level_frame_buffer #(
    .channel_count  (channel_count),
    .indicator_width(indicator_width)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (i_valid & i_ready_q),
    .wr_data   (i_array),
    .snap      (snap_ok),
    .all_fresh (all_fresh),
    .buf_data  (buf_data),
    .frame_data(frame_data),
    .overrun   (o_overrun)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_array_d = o_array_q;
    next_idx  = idx_q + 1'b1;
    if (snap_ok) begin
      // Frame register loads at this same edge, so beat 0 is taken from the
      // buffer contents the snapshot is copying.
      state_d   = EMIT;
      idx_d     = '0;
      o_valid_d = 1'b1;
      o_last_d  = (LAST_IDX == '0);
      o_array_d = buf_data[indicator_width-1:0];
    end else if (hs) begin
      if (o_last_q) begin
        state_d   = COLLECT;
        idx_d     = '0;
        o_valid_d = 1'b0;
        o_last_d  = 1'b0;
      end else begin
        idx_d     = next_idx;
        o_last_d  = (next_idx == LAST_IDX);
        o_array_d = frame_data[int'(next_idx)*indicator_width +: indicator_width];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      i_ready_q <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_array_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      i_ready_q <= '1;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_array_q <= o_array_d;
    end
  end

  assign i_ready   = i_ready_q;
  assign o_valid   = o_valid_q;
  assign o_channel = idx_q;
  assign o_last    = o_last_q;
  assign o_array   = o_array_q;

endmodule

// File: tb/tb_level_frame_scheduler.sv
// Bench for level_frame_scheduler: directed scenarios followed by randomized
// traffic, checked every cycle against a queue-of-beats reference model.
module tb_level_frame_scheduler;

  localparam int CC = 2;
  localparam int IW = 32;
  localparam int CB = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CC-1:0]     i_valid = '0;
  logic [CC-1:0]     i_ready;
  logic [CC*IW-1:0]  i_array = '0;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [CB-1:0]     o_channel;
  logic              o_last;
  logic [IW-1:0]     o_array;
  logic [CC-1:0]     o_overrun;

  int checks = 0;
  int errors = 0;

  level_frame_scheduler #(.channel_count(CC), .indicator_width(IW)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .i_array(i_array), .o_valid(o_valid), .o_ready(o_ready),
    .o_channel(o_channel), .o_last(o_last), .o_array(o_array),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Reference model: buffers, fresh flags and a queue of beats still owed.
  typedef struct { int ch; logic [IW-1:0] data; bit last; } beat_t;
  beat_t         q[$];
  logic [IW-1:0] mbuf[CC];
  bit            mfresh[CC];
  logic [CC-1:0] movr;
  bit            mready;

  task automatic chk(input string tag, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int c = 0; c < CC; c++) begin mbuf[c] = '0; mfresh[c] = 0; end
    movr = '0;
    mready = 0;
  endtask

  task automatic model_edge();
    bit hs, allf, snap, w;
    hs   = (q.size() > 0) && o_ready;
    allf = 1;
    for (int c = 0; c < CC; c++) allf &= mfresh[c];
    snap = allf && (q.size() == 0 || (hs && q.size() == 1));
    if (hs) void'(q.pop_front());
    if (snap)
      for (int c = 0; c < CC; c++) q.push_back('{c, mbuf[c], c == CC-1});
    for (int c = 0; c < CC; c++) begin
      w = i_valid[c] && mready;
      if (w && mfresh[c] && !snap) movr[c] = 1'b1;
      if (w) mbuf[c] = i_array[c*IW +: IW];
      if (snap) mfresh[c] = w;
      else if (w) mfresh[c] = 1;
    end
    mready = 1;
  endtask

  task automatic compare_all();
    chk("i_ready", i_ready, {CC{mready}});
    chk("o_valid", o_valid, q.size() > 0);
    chk("o_overrun", o_overrun, movr);
    if (q.size() > 0) begin
      chk("o_channel", o_channel, q[0].ch);
      chk("o_array", o_array, q[0].data);
      chk("o_last", o_last, q[0].last);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    i_valid = '0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [CC-1:0] v, input logic [IW-1:0] d0, input logic [IW-1:0] d1);
    i_valid = v;
    i_array = {d1, d0};
    step();
    i_valid = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_i_ready", i_ready, '0);
    chk("rst_o_valid", o_valid, '0);
    chk("rst_o_channel", o_channel, '0);
    chk("rst_o_last", o_last, '0);
    chk("rst_o_array", o_array, '0);
    chk("rst_o_overrun", o_overrun, '0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // 1: reset, then idle
    repeat (2) step();
    check_reset_outputs();
    reset = 1'b0;
    idle(20);

    // 2: ch0 then ch1, two beats in order
    idle(4);
    wr(2'b01, 32'h0000_00FF, 32'h0);
    idle(3);
    wr(2'b10, 32'h0, 32'h0000_FFFF);
    idle(4);

    // 3: pending frame held under back-pressure, no tearing
    o_ready = 1'b0;
    wr(2'b11, 32'hA5A5_0001, 32'h5A5A_0002);
    step();
    wr(2'b01, 32'h1, 32'h0);
    idle(3);
    o_ready = 1'b1;
    idle(4);

    // 4: overrun on ch0, frame carries latest value
    wr(2'b01, 32'h3, 32'h0);
    wr(2'b01, 32'h7, 32'h0);
    wr(2'b10, 32'h0, 32'h1234);
    idle(4);
    wr(2'b11, 32'h11, 32'h22);
    idle(4);

    // 5: back-to-back frames with no bubble
    wr(2'b11, 32'hB0, 32'hB1);
    wr(2'b11, 32'hC0, 32'hC1);
    wr(2'b11, 32'hD0, 32'hD1);
    idle(8);

    // 6: reset during beat 0
    wr(2'b11, 32'hE0, 32'hE1);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    step();
    reset = 1'b0;
    idle(6);
    wr(2'b11, 32'hF0, 32'hF1);
    idle(4);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < CC; c++) i_valid[c] = ($urandom_range(0, 9) < 3);
      for (int c = 0; c < CC; c++) i_array[c*IW +: IW] = $urandom;
      o_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1;
        #1;
        check_reset_outputs();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    i_valid = '0;
    o_ready = 1'b1;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
